// File: rtl/reg_wr_ctrl_if.sv
// Purpose : bundle of the requester, register-file write/read and forwarding signals of reg_wr_ctrl.
// Latency : n/a (wiring only).
// Backpressure: reqN_ready qualifies reqN_valid; a requester holds addr/data until accepted.
// Ports (slave = controller side):
//   req0_*/req1_* : writeback requesters (valid/addr/data in, ready out)
//   wr_*          : single write port towards reg_file
//   rd_addr1/2, rf_data1/2 in; rd_data1/2 forwarded read data out; init_done out
interface reg_wr_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 2
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [WORD_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [WORD_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [WORD_W-1:0] rf_data1;
    logic [WORD_W-1:0] rf_data2;
    logic [WORD_W-1:0] rd_data1;
    logic [WORD_W-1:0] rd_data2;
    logic              init_done;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data,
        input  rd_addr1, rd_addr2, rf_data1, rf_data2,
        output rd_data1, rd_data2, init_done
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data,
        output rd_addr1, rd_addr2, rf_data1, rf_data2,
        input  rd_data1, rd_data2, init_done
    );
endinterface

// File: rtl/reg_wr_ctrl.sv
// Purpose : zero the register file after reset, then round-robin two writeback requesters onto its write port, with read forwarding.
// Latency : accept at edge k, write port driven during cycle k..k+1, file updated at edge k+1; forwarding is combinational.
// Backpressure: at most one requester ready per cycle (never without valid); none during the zeroing walk.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : reg_wr_ctrl_if.slave (requesters, write port, read/forward path, init_done)
module reg_wr_ctrl #(
    parameter int WORD_W = 8,
    parameter int REG_N  = 4,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  logic         clk,
    input  logic         rst,
    reg_wr_ctrl_if.slave bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              last_q, last_d;
    logic              gnt0, gnt1;

    // State and write-port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            last_q    <= 1'b1;  // requester 0 wins the first contention
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            last_q    <= last_d;
        end
    end

    // Next state: leave INIT on the edge that issues the last zeroing write
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && cnt_q == ADDR_W'(REG_N - 1)) begin
            state_d = ST_RUN;
        end
    end

    // Outputs: grant and next write-port contents
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        last_d    = last_q;
        if (state_q == ST_INIT) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = '0;
            cnt_d     = cnt_q + 1'b1;
        end else begin
            // Under contention the requester that did not win last time goes first
            gnt0 = bus.req0_valid && (!bus.req1_valid || last_q);
            gnt1 = bus.req1_valid && (!bus.req0_valid || !last_q);
            if (gnt0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = bus.req0_addr;
                wr_data_d = bus.req0_data;
                last_d    = 1'b0;
            end else if (gnt1) begin
                wr_en_d   = 1'b1;
                wr_addr_d = bus.req1_addr;
                wr_data_d = bus.req1_data;
                last_d    = 1'b1;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.init_done  = (state_q == ST_RUN);

    // The file only holds a write after the following edge, so reads of the
    // address being written this cycle take the in-flight data instead.
    assign bus.rd_data1 = (wr_en_q && wr_addr_q == bus.rd_addr1) ? wr_data_q : bus.rf_data1;
    assign bus.rd_data2 = (wr_en_q && wr_addr_q == bus.rd_addr2) ? wr_data_q : bus.rf_data2;
endmodule
